// File: rtl/serial_right_shifter.sv
// rtl/serial_right_shifter.sv - multi-cycle 32-bit SRL/SRA shifter, one bit position per clock
module serial_right_shifter (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        ctrl_start,
    input  logic [31:0] data_operandA,
    input  logic [4:0]  ctrl_shiftamt,
    input  logic        ctrl_arith,
    output logic [31:0] data_result,
    output logic        data_shiftout,
    output logic        data_resultRDY,
    output logic        ctrl_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_count;
    logic        r_fill;
    logic [31:0] r_result;
    logic        r_shiftout;
    logic        w_accept;

    // A new operation may be loaded from IDLE or during the single DONE cycle.
    assign w_accept = ctrl_start && (r_state != SHIFT);

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_next_state = (ctrl_shiftamt == 5'd0) ? DONE : SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                if (r_count == 5'd1) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Fill bit is frozen at load so SRA keeps replicating the original sign.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_result   <= 32'd0;
            r_shiftout <= 1'b0;
            r_count    <= 5'd0;
            r_fill     <= 1'b0;
        end else if (w_accept) begin
            r_result   <= data_operandA;
            r_shiftout <= 1'b0;
            r_count    <= ctrl_shiftamt;
            r_fill     <= ctrl_arith & data_operandA[31];
        end else if (r_state == SHIFT) begin
            r_result   <= {r_fill, r_result[31:1]};
            r_shiftout <= r_result[0];
            r_count    <= r_count - 5'd1;
        end
    end

    assign data_result    = r_result;
    assign data_shiftout  = r_shiftout;
    assign data_resultRDY = (r_state == DONE);
    assign ctrl_busy      = (r_state == SHIFT);

endmodule

// File: tb/tb_serial_right_shifter.sv
// tb/tb_serial_right_shifter.sv - self-checking bench for serial_right_shifter
module tb_serial_right_shifter;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [4:0]  ctrl_shiftamt = 5'd0;
    logic        ctrl_arith = 1'b0;
    logic [31:0] data_result;
    logic        data_shiftout;
    logic        data_resultRDY;
    logic        ctrl_busy;

    serial_right_shifter dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .ctrl_start     (ctrl_start),
        .data_operandA  (data_operandA),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .ctrl_arith     (ctrl_arith),
        .data_result    (data_result),
        .data_shiftout  (data_shiftout),
        .data_resultRDY (data_resultRDY),
        .ctrl_busy      (ctrl_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] operand;
        logic [4:0]  amt;
        logic        arith;
        logic [31:0] exp_result;
        logic        exp_shiftout;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic        shiftout;
        int          busy;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          busy_cnt = 0;
    int          rdy_cnt = 0;
    logic [31:0] last_result = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every ready pulse pops one expectation.
    always @(negedge clock) begin
        if (!ctrl_reset) begin
            busy_cnt = 0;
        end else begin
            if (ctrl_busy) busy_cnt++;
            if (data_resultRDY) begin
                rdy_cnt++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rdy: got ready pulse expected none");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("result", data_result, e.result);
                    chk("shiftout", {31'd0, data_shiftout}, {31'd0, e.shiftout});
                    chk("busy_cycles", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    function automatic exp_t model(input logic [31:0] op, input logic [4:0] amt, input logic arith);
        exp_t e;
        if (arith) e.result = $signed(op) >>> amt;
        else       e.result = op >> amt;
        e.shiftout = (amt == 5'd0) ? 1'b0 : op[amt - 5'd1];
        e.busy     = int'(amt);
        return e;
    endfunction

    // Drive a start at the current (negedge) time; hold it across one rising edge.
    task automatic start_op(input logic [31:0] op, input logic [4:0] amt, input logic arith,
                            input exp_t e);
        data_operandA = op;
        ctrl_shiftamt = amt;
        ctrl_arith    = arith;
        ctrl_start    = 1'b1;
        sb_q.push_back(e);
        last_result   = e.result;
        @(posedge clock);
        #1 ctrl_start = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_hold();
        repeat (3) @(negedge clock);
        chk("hold_result", data_result, last_result);
        chk("hold_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("hold_busy", {31'd0, ctrl_busy}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        exp_t e;
        int   rdy_before;
        int   k;

        vecs[0] = '{32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b0};
        vecs[1] = '{32'h80000000, 5'd4,  1'b1, 32'hF8000000, 1'b0};
        vecs[2] = '{32'h7FFFFFF0, 5'd4,  1'b1, 32'h07FFFFFF, 1'b0};
        vecs[3] = '{32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF, 1'b0};
        vecs[4] = '{32'h00000003, 5'd1,  1'b0, 32'h00000001, 1'b1};
        vecs[5] = '{32'hF0F0F0F0, 5'd5,  1'b1, 32'hFF878787, 1'b1};
        vecs[6] = '{32'hF0F0F0F0, 5'd5,  1'b0, 32'h07878787, 1'b1};
        vecs[7] = '{32'h80000001, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0};

        repeat (3) @(negedge clock);
        ctrl_reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_result", data_result, 32'd0);
        chk("reset_shiftout", {31'd0, data_shiftout}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, ctrl_busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            e.result   = vecs[i].exp_result;
            e.shiftout = vecs[i].exp_shiftout;
            e.busy     = int'(vecs[i].amt);
            start_op(vecs[i].operand, vecs[i].amt, vecs[i].arith, e);
            drain();
            check_hold();
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] op;
            logic [4:0]  amt;
            logic        ar;
            op  = $urandom;
            amt = 5'($urandom_range(0, 31));
            ar  = 1'($urandom_range(0, 1));
            start_op(op, amt, ar, model(op, amt, ar));
            drain();
        end

        // Back-to-back: second start lands in the DONE cycle.
        e = '{32'h00000001, 1'b1, 1};
        start_op(32'h00000003, 5'd1, 1'b0, e);
        k = 0;
        while (!data_resultRDY && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("b2b_rdy_seen", {31'd0, data_resultRDY}, 32'd1);
        e = '{32'h00000001, 1'b0, 8};
        start_op(32'h00000100, 5'd8, 1'b0, e);
        @(negedge clock);
        chk("b2b_no_gap_busy", {31'd0, ctrl_busy}, 32'd1);
        drain();
        check_hold();

        // Start held high with the operand changing while SHIFT runs.
        rdy_before = rdy_cnt;
        e = '{32'h0000FFFF, 1'b0, 16};
        data_operandA = 32'hFFFF0000;
        ctrl_shiftamt = 5'd16;
        ctrl_arith    = 1'b0;
        ctrl_start    = 1'b1;
        sb_q.push_back(e);
        last_result   = e.result;
        repeat (10) begin
            @(negedge clock);
            data_operandA = $urandom;
            ctrl_shiftamt = 5'($urandom);
            ctrl_arith    = 1'($urandom);
        end
        ctrl_start = 1'b0;
        drain();
        check_hold();
        chk("held_start_one_rdy", rdy_cnt - rdy_before, 32'd1);

        // Asynchronous reset abandons a shift in progress.
        e = '{32'h00000000, 1'b0, 20};
        start_op(32'hA5A5A5A5, 5'd20, 1'b0, e);
        k = 0;
        while (busy_cnt < 5 && k < 50) begin
            @(negedge clock);
            k++;
        end
        rdy_before = rdy_cnt;
        #2 ctrl_reset = 1'b0;
        #1;
        sb_q.delete();
        chk("async_rst_result", data_result, 32'd0);
        chk("async_rst_shiftout", {31'd0, data_shiftout}, 32'd0);
        chk("async_rst_busy", {31'd0, ctrl_busy}, 32'd0);
        chk("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b1;
        repeat (25) @(negedge clock);
        chk("no_rdy_after_abort", rdy_cnt - rdy_before, 32'd0);

        e = '{32'h00123456, 1'b0, 8};
        start_op(32'h12345678, 5'd8, 1'b0, e);
        drain();
        check_hold();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
